// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ==========================================================================
// ram_bist_ctrl : fill/read-back self-test sequencer for a single-port RAM
// Revision 1.0
// ==========================================================================
module ram_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_MAX   = '1;
  localparam logic [ADDR_WIDTH:0]   C_ERR_MAX    = '1;
  localparam logic [1:0]            C_DRAIN_LAST = 2'(RD_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH:0]     err_cnt_q, err_cnt_d;
  logic                    fev_q, fev_d;
  logic [ADDR_WIDTH-1:0]   fea_q, fea_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [1:0]              drain_q, drain_d;

  // Compare pipeline: stage RD_LATENCY-1 lines up with ram_rd_data.
  logic [RD_LATENCY-1:0]                 pv_q, pv_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pa_q, pa_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pe_q, pe_d;

  logic push;
  logic head_mismatch;

  assign head_mismatch = pv_q[RD_LATENCY-1] && (ram_rd_data != pe_q[RD_LATENCY-1]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fea_d     = fea_q;
    seed_d    = seed_q;
    exp_d     = exp_q;
    drain_d   = drain_q;
    push      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      if (head_mismatch) begin
        if (err_cnt_q != C_ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (!fev_q) begin
          fev_d = 1'b1;
          fea_d = pa_q[RD_LATENCY-1];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            seed_d    = seed;
            err_cnt_d = '0;
            fev_d     = 1'b0;
            fea_d     = '0;
            pass_d    = 1'b0;
            addr_d    = '0;
            wr_data_d = seed;
            state_d   = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Within the fill the pattern advances by one per address, so the
          // data register simply increments alongside the counter.
          if (addr_q == C_ADDR_MAX) begin
            addr_d  = '0;
            exp_d   = seed_q;
            state_d = ST_READ;
          end else begin
            addr_d    = addr_q + 1'b1;
            wr_data_d = wr_data_q + 1'b1;
          end
        end
        ST_READ: begin
          push  = 1'b1;
          exp_d = exp_q + 1'b1;
          if (addr_q == C_ADDR_MAX) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == C_DRAIN_LAST) begin
            pass_d  = (err_cnt_d == '0);
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    pv_d    = '0;
    pa_d    = '0;
    pe_d    = '0;
    pv_d[0] = push;
    pa_d[0] = addr_q;
    pe_d[0] = exp_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    if (abort) pv_d = '0;

    wr_en_d = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fea_q     <= '0;
      seed_q    <= '0;
      exp_q     <= '0;
      drain_q   <= '0;
      pv_q      <= '0;
      pa_q      <= '0;
      pe_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fea_q     <= fea_d;
      seed_q    <= seed_d;
      exp_q     <= exp_d;
      drain_q   <= drain_d;
      pv_q      <= pv_d;
      pa_q      <= pa_d;
      pe_q      <= pe_d;
    end
  end

  assign ram_addr        = addr_q;
  assign ram_wr_data     = wr_data_q;
  assign ram_wr_en       = wr_en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_ram_bist_ctrl : directed bench for ram_bist_ctrl, latency-1 and -2 RAMs
// Revision 1.0
// ==========================================================================
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 1: RD_LATENCY = 1
  logic       start1 = 1'b0, abort1 = 1'b0, fault1 = 1'b0;
  logic [7:0] seed1 = 8'h00;
  logic [4:0] addr1;
  logic [7:0] wd1, rd1;
  logic       we1, busy1, done1, pass1, fev1;
  logic [5:0] err1;
  logic [4:0] fea1;
  logic [7:0] mem1 [32];

  // Instance 2: RD_LATENCY = 2
  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [7:0] seed2 = 8'h00;
  logic [4:0] addr2;
  logic [7:0] wd2, rd2, rd2_pre;
  logic       we2, busy2, done2, pass2, fev2;
  logic [5:0] err2;
  logic [4:0] fea2;
  logic [7:0] mem2 [32];

  logic [12:0] wq1[$];
  logic [12:0] wq2[$];
  logic [12:0] e1, e2;

  ram_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .seed(seed1),
    .ram_addr(addr1), .ram_wr_data(wd1), .ram_wr_en(we1), .ram_rd_data(rd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_valid(fev1), .first_err_addr(fea1)
  );

  ram_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .seed(seed2),
    .ram_addr(addr2), .ram_wr_data(wd2), .ram_wr_en(we2), .ram_rd_data(rd2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_valid(fev2), .first_err_addr(fea2)
  );

  // Behavioural RAMs; RAM 1 can corrupt bit 0 of locations 7 and 20.
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    rd1 <= mem1[addr1] ^ ((fault1 && (addr1 == 5'd7 || addr1 == 5'd20)) ? 8'h01 : 8'h00);
  end

  always @(posedge clk) begin
    if (we2) mem2[addr2] <= wd2;
    rd2_pre <= mem2[addr2];
    rd2     <= rd2_pre;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboards: every observed write must match the next queued one.
  always @(negedge clk) begin
    if (rst_n && we1 === 1'b1) begin
      total++;
      assert (wq1.size() > 0) else begin
        bad++;
        $error("FAIL wr1_unexpected: observed write addr=0x%0h, expected none", addr1);
      end
      if (wq1.size() > 0) begin
        e1 = wq1.pop_front();
        chk("wr1_addr", 32'(addr1), 32'(e1[12:8]));
        chk("wr1_data", 32'(wd1), 32'(e1[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && we2 === 1'b1) begin
      total++;
      assert (wq2.size() > 0) else begin
        bad++;
        $error("FAIL wr2_unexpected: observed write addr=0x%0h, expected none", addr2);
      end
      if (wq2.size() > 0) begin
        e2 = wq2.pop_front();
        chk("wr2_addr", 32'(addr2), 32'(e2[12:8]));
        chk("wr2_data", 32'(wd2), 32'(e2[7:0]));
      end
    end
  end

  // Present start for one accepting edge and queue the expected fill.
  task automatic go(input int which, input logic [7:0] s);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (which == 1) wq1.push_back({5'(i), 8'(i) + s});
      else            wq2.push_back({5'(i), 8'(i) + s});
    end
    if (which == 1) begin seed1 = s; start1 = 1'b1; end
    else            begin seed2 = s; start2 = 1'b1; end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Cycle n is the n-th cycle after the accepting edge, sampled at its negedge.
  task automatic wait_done(input int which, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (which == 2 && cyc == 40) start2 = 1'b1;
      if (which == 2 && cyc == 50) start2 = 1'b0;
    end while (((which == 1) ? done1 : done2) !== 1'b1 && cyc < 200);
  endtask

  int cyc;
  int ndone;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_wdata", 32'(wd1), 0);
    chk("rst_we", 32'(we1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_fev", 32'(fev1), 0);
    chk("rst_fea", 32'(fea1), 0);
    chk("rst_busy2", 32'(busy2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy1), 0);

    // Seed 0, clean RAM
    go(1, 8'h00);
    wait_done(1, cyc);
    chk("s0_done_cycle", 32'(cyc), 66);
    chk("s0_pass", 32'(pass1), 1);
    chk("s0_err", 32'(err1), 0);
    chk("s0_fev", 32'(fev1), 0);
    @(negedge clk);
    chk("s0_done_pulse", 32'(done1), 0);
    chk("s0_busy_after", 32'(busy1), 0);
    chk("s0_wq_empty", 32'(wq1.size()), 0);

    // Seed 0xF0: pattern wraps through 0xFF
    go(1, 8'hF0);
    wait_done(1, cyc);
    chk("sF0_done_cycle", 32'(cyc), 66);
    chk("sF0_pass", 32'(pass1), 1);
    chk("sF0_wq_empty", 32'(wq1.size()), 0);

    // Corrupted reads at 7 and 20
    fault1 = 1'b1;
    go(1, 8'h5A);
    wait_done(1, cyc);
    chk("flt_done_cycle", 32'(cyc), 66);
    chk("flt_err", 32'(err1), 2);
    chk("flt_fev", 32'(fev1), 1);
    chk("flt_fea", 32'(fea1), 7);
    chk("flt_pass", 32'(pass1), 0);
    fault1 = 1'b0;
    @(negedge clk);
    chk("flt_pass_hold", 32'(pass1), 0);

    // Abort while writing address 10
    go(1, 8'h33);
    cyc = 0;
    while (!(addr1 == 5'd10 && we1 === 1'b1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abt_reach_addr10", 32'(addr1), 10);
    abort1 = 1'b1;
    @(posedge clk);
    #1 abort1 = 1'b0;
    chk("abt_busy", 32'(busy1), 0);
    chk("abt_we", 32'(we1), 0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) ndone++;
    end
    chk("abt_no_done", 32'(ndone), 0);
    chk("abt_pass", 32'(pass1), 0);
    chk("abt_addr_hold", 32'(addr1), 10);
    chk("abt_writes_left", 32'(wq1.size()), 21);
    wq1.delete();

    go(1, 8'h00);
    wait_done(1, cyc);
    chk("rst_run_done_cycle", 32'(cyc), 66);
    chk("rst_run_pass", 32'(pass1), 1);
    chk("rst_run_wq_empty", 32'(wq1.size()), 0);

    // Two-cycle RAM; start re-asserted during READ must be ignored
    go(2, 8'h11);
    wait_done(2, cyc);
    chk("l2_done_cycle", 32'(cyc), 67);
    chk("l2_pass", 32'(pass2), 1);
    chk("l2_err", 32'(err2), 0);
    @(negedge clk);
    chk("l2_done_pulse", 32'(done2), 0);
    chk("l2_busy_after", 32'(busy2), 0);
    chk("l2_wq_empty", 32'(wq2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
